irq_timer: RTL and testbench

//  Memory-mapped interval timer and interrupt source for the single-cycle MIPS core.

---
 rtl/mips_mmio_pkg.sv | 48 ++++
 rtl/timer_prescaler.sv | 35 +++
 rtl/irq_timer.sv | 108 ++++++++++
 tb/tb_irq_timer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mmio_pkg.sv
// ============================================================================
// Package : mips_mmio_pkg
// Brief   : Shared MMIO constants for the MIPS core bus and its timer block.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package mips_mmio_pkg;

    localparam logic [31:0] TIMER_BASE = 32'h4000_0000;

    localparam logic [3:0] TH_OFS   = 4'h0;
    localparam logic [3:0] TL_OFS   = 4'h4;
    localparam logic [3:0] TCON_OFS = 4'h8;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    // Exception vectors used by the controller
    localparam logic [31:0] ILLOP = 32'h8000_0004;
    localparam logic [31:0] XADR  = 32'h8000_0008;

    typedef enum logic [1:0] {
        REG_TH   = 2'd0,
        REG_TL   = 2'd1,
        REG_TCON = 2'd2,
        REG_NONE = 2'd3
    } timer_reg_e;

    // Word-granular decode of a bus address against a 16-byte timer window
    function automatic timer_reg_e decode_reg(input logic [31:0] a, input logic [31:0] base);
        timer_reg_e r;
        r = REG_NONE;
        if (a[31:4] == base[31:4]) begin
            case ({a[3:2], 2'b00})
                TH_OFS:   r = REG_TH;
                TL_OFS:   r = REG_TL;
                TCON_OFS: r = REG_TCON;
                default:  r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module : timer_prescaler
// Brief  : Divides clk by PRESCALE while enabled; count holds when disabled.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_pcnt;

    // With PRESCALE=1 the counter is pinned at 0 and tick follows en
    assign tick = en && (r_pcnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (en) begin
            r_pcnt <= tick ? '0 : r_pcnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_timer.sv
// ============================================================================
// Module : irq_timer
// Brief  : Memory-mapped reloading interval timer with sticky interrupt status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module irq_timer
    import mips_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE,
    parameter int          PRESCALE  = 1,
    parameter logic [31:0] TH_RST    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irqout
);

    timer_reg_e  w_reg;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_ovf;
    logic        w_unused_addr_lsb;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic        r_irq;

    assign w_reg             = decode_reg(addr, BASE_ADDR);
    assign sel               = (w_reg != REG_NONE);
    assign w_unused_addr_lsb = ^addr[1:0];

    assign w_wr_th   = mem_wr && (w_reg == REG_TH);
    assign w_wr_tl   = mem_wr && (w_reg == REG_TL);
    assign w_wr_tcon = mem_wr && (w_reg == REG_TCON);

    always_comb begin
        rdata = 32'b0;
        if (mem_rd) begin
            case (w_reg)
                REG_TH:   rdata = r_th;
                REG_TL:   rdata = r_tl;
                REG_TCON: rdata = {29'b0, r_tcon};
                default:  rdata = 32'b0;
            endcase
        end
    end

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (r_tcon[TCON_EN]),
        .tick  (w_tick)
    );

    // A software TL write on the wrap cycle takes precedence and cancels the overflow
    assign w_ovf = w_tick && (&r_tl) && !w_wr_tl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th   <= TH_RST;
            r_tl   <= 32'b0;
            r_tcon <= 3'b000;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr_th) begin
                r_th <= wdata;
            end

            if (w_wr_tl) begin
                r_tl <= wdata;
            end else if (w_tick) begin
                r_tl <= (&r_tl) ? r_th : r_tl + 32'd1;
            end

            if (w_wr_tcon) begin
                r_tcon[TCON_EN] <= wdata[TCON_EN];
                r_tcon[TCON_IE] <= wdata[TCON_IE];
            end

            // Setting on overflow beats a simultaneous software clear
            if (w_ovf && r_tcon[TCON_IE]) begin
                r_tcon[TCON_ST] <= 1'b1;
            end else if (w_wr_tcon) begin
                r_tcon[TCON_ST] <= wdata[TCON_ST];
            end

            r_irq <= r_tcon[TCON_IE] && r_tcon[TCON_ST];
        end
    end

    assign irqout = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_irq_timer.sv
// ============================================================================
// Module : tb_irq_timer
// Brief  : Directed and randomized checks of irq_timer against a cycle model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_irq_timer;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_UNM  = 32'h4000_000C;
    localparam logic [31:0] A_OUT  = 32'h4000_0010;
    localparam int          P      = 1;

    logic        clk;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        mem_wr, mem_rd, sel, irqout;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_wr, b_rd, b_sel, b_irq;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_th, m_tl;
    bit          m_en, m_ie, m_st, m_irq;
    int          m_pcnt;

    irq_timer #(.PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .rdata(rdata), .sel(sel), .irqout(irqout)
    );

    irq_timer #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .addr(b_addr), .wdata(b_wdata), .mem_wr(b_wr),
        .mem_rd(b_rd), .rdata(b_rdata), .sel(b_sel), .irqout(b_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] base;
        base = A_TH;
        return (a[31:4] == base[31:4]) && (a[3:2] != 2'b11);
    endfunction

    task automatic model_reset();
        m_th = 32'h0; m_tl = 32'h0;
        m_en = 0; m_ie = 0; m_st = 0; m_irq = 0;
        m_pcnt = 0;
    endtask

    // One clock of the timer, evaluated from the register-level rules
    task automatic model_step(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit          hit, tick, ovf;
        logic [31:0] n_tl;
        int          idx;
        hit  = wr && in_win(a);
        idx  = int'(a[3:2]);
        tick = m_en && (m_pcnt == P - 1);
        ovf  = 0;
        n_tl = m_tl;
        if (tick) begin
            if (m_tl == 32'hFFFF_FFFF) begin n_tl = m_th; ovf = 1; end
            else n_tl = m_tl + 32'd1;
        end
        if (hit && idx == 1) begin n_tl = d; ovf = 0; end
        m_irq = m_ie && m_st;
        if (hit && idx == 2) m_st = d[2];
        if (ovf && m_ie) m_st = 1;
        if (m_en) m_pcnt = (m_pcnt + 1) % P;
        if (hit && idx == 2) begin m_en = d[0]; m_ie = d[1]; end
        if (hit && idx == 0) m_th = d;
        m_tl = n_tl;
    endtask

    task automatic bus_cycle(input bit wr, input logic [31:0] a, input logic [31:0] d);
        mem_wr = wr; addr = a; wdata = d;
        @(posedge clk);
        model_step(wr, a, d);
        #1;
        mem_wr = 0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic b_cycle(input bit wr, input logic [31:0] a, input logic [31:0] d);
        b_wr = wr; b_addr = a; b_wdata = d;
        mem_wr = 0;
        @(posedge clk);
        model_step(0, 32'h0, 32'h0);
        #1;
        b_wr = 0; b_addr = 32'h0; b_wdata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic s);
        mem_rd = 1; addr = a;
        #1;
        v = rdata; s = sel;
        mem_rd = 0;
    endtask

    task automatic b_rd_t(input logic [31:0] a, output logic [31:0] v);
        b_rd = 1; b_addr = a;
        #1;
        v = b_rdata;
        b_rd = 0;
    endtask

    task automatic test_reset();
        logic [31:0] v; logic s;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        rd(A_TH, v, s);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL reset_th: got %h expected 0", v); end
        rd(A_TL, v, s);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL reset_tl: got %h expected 0", v); end
        rd(A_TCON, v, s);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL reset_tcon: got %h expected 0", v); end
        vectors++; if (irqout !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irqout); end
        b_rd_t(A_TL, v);
        vectors++; if (v !== 32'h0 || b_irq !== 1'b0) begin miscompares++; $display("FAIL reset_dut4: tl %h irq %b expected 0/0", v, b_irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] v; logic s;
        logic [31:0] exp_tl [4];
        exp_tl = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        bus_cycle(1, A_TH, 32'hFFFF_FFFC);
        bus_cycle(1, A_TL, 32'hFFFF_FFFC);
        bus_cycle(1, A_TCON, 32'h3);
        for (int i = 0; i < 4; i++) begin
            bus_cycle(0, 32'h0, 32'h0);
            rd(A_TL, v, s);
            vectors++; if (v !== exp_tl[i]) begin miscompares++; $display("FAIL ovf_tl%0d: got %h expected %h", i, v, exp_tl[i]); end
        end
        rd(A_TCON, v, s);
        vectors++; if (v !== 32'h7) begin miscompares++; $display("FAIL ovf_st: got %h expected 7", v); end
        vectors++; if (irqout !== 1'b0) begin miscompares++; $display("FAIL ovf_irq_early: got %b expected 0", irqout); end
        bus_cycle(0, 32'h0, 32'h0);
        vectors++; if (irqout !== 1'b1) begin miscompares++; $display("FAIL ovf_irq: got %b expected 1", irqout); end
    endtask

    task automatic test_pending();
        logic [31:0] v; logic s;
        bus_cycle(1, A_TCON, 32'h3);
        rd(A_TCON, v, s);
        vectors++; if (v !== 32'h3) begin miscompares++; $display("FAIL pend_clear: got %h expected 3", v); end
        vectors++; if (irqout !== 1'b1) begin miscompares++; $display("FAIL pend_irq_hold: got %b expected 1", irqout); end
        bus_cycle(0, 32'h0, 32'h0);
        rd(A_TL, v, s);
        vectors++; if (irqout !== 1'b0) begin miscompares++; $display("FAIL pend_irq_fall: got %b expected 0", irqout); end
        vectors++; if (v !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL pend_tl: got %h expected ffffffff", v); end
        bus_cycle(0, 32'h0, 32'h0);
        bus_cycle(0, 32'h0, 32'h0);
        bus_cycle(1, A_TCON, 32'h7);
        rd(A_TCON, v, s);
        vectors++; if (v !== 32'h7) begin miscompares++; $display("FAIL pend_set_keep: got %h expected 7", v); end
        bus_cycle(0, 32'h0, 32'h0);
        vectors++; if (irqout !== 1'b1) begin miscompares++; $display("FAIL pend_irq_keep: got %b expected 1", irqout); end
    endtask

    task automatic test_no_ie();
        logic [31:0] v; logic s;
        bus_cycle(1, A_TCON, 32'h0);
        bus_cycle(1, A_TH, 32'hFFFF_FFFF);
        bus_cycle(1, A_TL, 32'hFFFF_FFFF);
        bus_cycle(1, A_TCON, 32'h1);
        for (int i = 0; i < 4; i++) begin
            bus_cycle(0, 32'h0, 32'h0);
            rd(A_TL, v, s);
            vectors++; if (v !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL noie_tl%0d: got %h expected ffffffff", i, v); end
            rd(A_TCON, v, s);
            vectors++; if (v !== 32'h1 || irqout !== 1'b0) begin miscompares++; $display("FAIL noie_st%0d: tcon %h irq %b expected 1/0", i, v, irqout); end
        end
    endtask

    task automatic test_collision();
        logic [31:0] v; logic s;
        bus_cycle(1, A_TCON, 32'h0);
        bus_cycle(1, A_TH, 32'h10);
        bus_cycle(1, A_TL, 32'hFFFF_FFFF);
        bus_cycle(1, A_TCON, 32'h3);
        bus_cycle(1, A_TCON, 32'h3);
        rd(A_TCON, v, s);
        vectors++; if (v !== 32'h7) begin miscompares++; $display("FAIL coll_clear_ovf: tcon %h expected 7", v); end
        rd(A_TL, v, s);
        vectors++; if (v !== 32'h10) begin miscompares++; $display("FAIL coll_reload: got %h expected 10", v); end
        bus_cycle(0, 32'h0, 32'h0);
        vectors++; if (irqout !== 1'b1) begin miscompares++; $display("FAIL coll_irq: got %b expected 1", irqout); end
        bus_cycle(1, A_TCON, 32'h0);
        bus_cycle(1, A_TL, 32'hFFFF_FFFF);
        bus_cycle(1, A_TCON, 32'h3);
        bus_cycle(1, A_TL, 32'h5);
        rd(A_TL, v, s);
        vectors++; if (v !== 32'h5) begin miscompares++; $display("FAIL coll_tl_wr: got %h expected 5", v); end
        rd(A_TCON, v, s);
        vectors++; if (v !== 32'h3) begin miscompares++; $display("FAIL coll_tl_st: tcon %h expected 3", v); end
        bus_cycle(0, 32'h0, 32'h0);
        rd(A_TL, v, s);
        vectors++; if (v !== 32'h6 || irqout !== 1'b0) begin miscompares++; $display("FAIL coll_after: tl %h irq %b expected 6/0", v, irqout); end
    endtask

    task automatic test_decode();
        logic [31:0] v; logic s;
        rd(A_UNM, v, s);
        vectors++; if (v !== 32'h0 || s !== 1'b0) begin miscompares++; $display("FAIL dec_c: rdata %h sel %b expected 0/0", v, s); end
        rd(A_OUT, v, s);
        vectors++; if (v !== 32'h0 || s !== 1'b0) begin miscompares++; $display("FAIL dec_10: rdata %h sel %b expected 0/0", v, s); end
        rd(A_TCON, v, s);
        vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL dec_sel: sel %b expected 1", s); end
        addr = A_TL; mem_rd = 0; #1;
        vectors++; if (rdata !== 32'h0 || sel !== 1'b1) begin miscompares++; $display("FAIL dec_nord: rdata %h sel %b expected 0/1", rdata, sel); end
        bus_cycle(1, A_UNM, 32'hFFFF_FFFF);
        bus_cycle(1, A_OUT, 32'h0);
        rd(A_TH, v, s);
        vectors++; if (v !== m_th) begin miscompares++; $display("FAIL dec_wr_th: got %h expected %h", v, m_th); end
        rd(A_TCON, v, s);
        vectors++; if (v !== {29'b0, m_st, m_ie, m_en}) begin miscompares++; $display("FAIL dec_wr_tcon: got %h expected %h", v, {29'b0, m_st, m_ie, m_en}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v; logic s;
        bus_cycle(1, A_TCON, 32'h0);
        bus_cycle(1, A_TL, 32'hFFFF_FFFF);
        bus_cycle(1, A_TCON, 32'h3);
        bus_cycle(0, 32'h0, 32'h0);
        bus_cycle(0, 32'h0, 32'h0);
        vectors++; if (irqout !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre: irq %b expected 1", irqout); end
        #2 reset = 1;
        #1;
        vectors++; if (irqout !== 1'b0) begin miscompares++; $display("FAIL rstmid_irq: irq %b expected 0", irqout); end
        rd(A_TCON, v, s);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL rstmid_tcon: got %h expected 0", v); end
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        b_cycle(1, A_TCON, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            b_cycle(0, 32'h0, 32'h0);
            b_rd_t(A_TL, v);
            if (k == 3 || k == 4 || k == 7 || k == 8) begin
                vectors++;
                if (v !== 32'(k / 4)) begin miscompares++; $display("FAIL pre_tl_k%0d: got %h expected %h", k, v, 32'(k / 4)); end
            end
        end
        b_cycle(0, 32'h0, 32'h0);
        b_cycle(0, 32'h0, 32'h0);
        #2 reset = 1;
        #1;
        b_rd_t(A_TL, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL pre_rst_tl: got %h expected 0", v); end
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        b_cycle(1, A_TCON, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            b_cycle(0, 32'h0, 32'h0);
            b_rd_t(A_TL, v);
            if (k >= 3) begin
                vectors++;
                if (v !== 32'(k / 4)) begin miscompares++; $display("FAIL pre_pcnt_k%0d: got %h expected %h", k, v, 32'(k / 4)); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, d, a;
        logic        s;
        int          op;
        bit          wr;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            wr = 1;
            d  = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            case (op)
                0, 1:    a = A_TH;
                2, 3:    a = A_TL;
                4, 5:    begin a = A_TCON; d = 32'($urandom_range(0, 7)) | ($urandom_range(0, 3) != 0 ? 32'h1 : 32'h0); end
                6:       a = ($urandom_range(0, 1) == 1) ? A_UNM : A_OUT;
                default: begin a = 32'h0; wr = 0; end
            endcase
            bus_cycle(wr, a, d);
            rd(A_TH, v, s);
            vectors++; if (v !== m_th) begin miscompares++; $display("FAIL rnd_th n=%0d: got %h expected %h", n, v, m_th); end
            rd(A_TL, v, s);
            vectors++; if (v !== m_tl) begin miscompares++; $display("FAIL rnd_tl n=%0d: got %h expected %h", n, v, m_tl); end
            rd(A_TCON, v, s);
            vectors++; if (v !== {29'b0, m_st, m_ie, m_en}) begin miscompares++; $display("FAIL rnd_tcon n=%0d: got %h expected %h", n, v, {29'b0, m_st, m_ie, m_en}); end
            vectors++; if (irqout !== m_irq) begin miscompares++; $display("FAIL rnd_irq n=%0d: got %b expected %b", n, irqout, m_irq); end
        end
    endtask

    initial begin
        reset = 0;
        addr = 32'h0; wdata = 32'h0; mem_wr = 0; mem_rd = 0;
        b_addr = 32'h0; b_wdata = 32'h0; b_wr = 0; b_rd = 0;
        model_reset();
        #1;
        test_reset();
        test_overflow();
        test_pending();
        test_no_ie();
        test_collision();
        test_decode();
        test_reset_mid();
        test_prescale();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
